// File: rtl/tt_um_serdes.sv
// Tiny Tapeout byte serdes: deserializes ui_in[0] into uo_out and retransmits each byte on uio_out[0].
// Optional macro SERDES_MSB_FIRST_EN switches both directions from LSB-first to MSB-first.
module tt_um_serdes (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    logic [7:0] rx_shift;
    logic [2:0] rx_bitcnt;
    logic [7:0] rx_data;
    logic [7:0] tx_shift;
    logic [2:0] tx_bitcnt;
    logic       tx_active;
    logic       rx_strobe;
    logic [4:0] rx_byte_count;

    logic [7:0] rx_next;
    logic [7:0] tx_next;
    logic       tx_serial;
    logic       rx_done;

    always_comb begin
`ifdef SERDES_MSB_FIRST_EN
        rx_next   = {rx_shift[6:0], ui_in[0]};
        tx_next   = {tx_shift[6:0], 1'b0};
        tx_serial = tx_active & tx_shift[7];
`else
        rx_next   = {ui_in[0], rx_shift[7:1]};
        tx_next   = {1'b0, tx_shift[7:1]};
        tx_serial = tx_active & tx_shift[0];
`endif
        rx_done   = (rx_bitcnt == 3'd7);
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift      <= '0;
            rx_bitcnt     <= '0;
            rx_data       <= '0;
            tx_shift      <= '0;
            tx_bitcnt     <= '0;
            tx_active     <= 1'b0;
            rx_strobe     <= 1'b0;
            rx_byte_count <= '0;
        end else if (!ena) begin
            rx_strobe <= 1'b0;
        end else begin
            rx_shift  <= rx_next;
            rx_bitcnt <= rx_bitcnt + 3'd1;
            rx_strobe <= rx_done;
            if (rx_done) begin
                rx_data       <= rx_next;
                rx_byte_count <= rx_byte_count + 5'd1;
            end
            // A fresh byte preempts the final shift, keeping the stream gapless.
            if (rx_done) begin
                tx_shift  <= rx_next;
                tx_bitcnt <= '0;
                tx_active <= 1'b1;
            end else if (tx_active) begin
                tx_shift  <= tx_next;
                tx_bitcnt <= tx_bitcnt + 3'd1;
                if (tx_bitcnt == 3'd7)
                    tx_active <= 1'b0;
            end
        end
    end

    assign uo_out  = rx_data;
    assign uio_out = {rx_byte_count, rx_strobe, tx_active, tx_serial};
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in[7:1], uio_in};

endmodule

// File: tb/tb_tt_um_serdes.sv
// Directed self-checking bench for tt_um_serdes; honours SERDES_MSB_FIRST_EN for line bit order.
module tb_tt_um_serdes;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int total = 0;
    int bad   = 0;

    tt_um_serdes dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Bit that goes on the line at position i for byte v.
    function automatic logic line_bit(input logic [7:0] v, input int i);
`ifdef SERDES_MSB_FIRST_EN
        return v[7-i];
`else
        return v[i];
`endif
    endfunction

    // Drive one serial bit, clock it in, and return 1 ns after the edge.
    task automatic send_bit(input logic b);
        ui_in[0]   = b;
        ui_in[7:1] = 7'($urandom);
        uio_in     = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(line_bit(v, i));
    endtask

    task automatic do_reset;
        ena   = 1'b0;
        rst_n = 1'b0;
        ui_in = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    task automatic test_reset;
        ena    = 1'b0;
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        rst_n  = 1'b0;
        #50;
        total++;
        if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
        total++;
        if (uio_oe !== 8'hFF) begin bad++; $display("FAIL uio_oe: got %h want ff", uio_oe); end
        rst_n = 1'b1;
        #20;
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL idle_uio_out: got %h want 00", uio_out); end
        ena = 1'b1;
    endtask

    // Four 0xFF bytes, then one 0x00 byte to close out the transmit window.
    task automatic test_ones;
        logic exp_s, exp_t;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_bit(i < 32);
            exp_s = (i % 8 == 7);
            exp_t = (i >= 7 && i <= 38);
            total++;
            if (uio_out[2] !== exp_s) begin bad++; $display("FAIL ones_strobe[%0d]: got %b want %b", i, uio_out[2], exp_s); end
            total++;
            if (uio_out[0] !== exp_t) begin bad++; $display("FAIL ones_tx[%0d]: got %b want %b", i, uio_out[0], exp_t); end
            if (i == 7) begin
                total++;
                if (uo_out !== 8'hFF) begin bad++; $display("FAIL ones_uo_out: got %h want ff", uo_out); end
            end
            if (i == 31) begin
                total++;
                if (uio_out[7:3] !== 5'd4) begin bad++; $display("FAIL ones_count: got %0d want 4", uio_out[7:3]); end
            end
        end
        total++;
        if (uio_out[7:3] !== 5'd5) begin bad++; $display("FAIL ones_count_after: got %0d want 5", uio_out[7:3]); end
        total++;
        if (uo_out !== 8'h00) begin bad++; $display("FAIL ones_last_byte: got %h want 00", uo_out); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] tx_obs;
        logic [15:0] tx_exp;
        logic [7:0]  vals [2];
        vals[0] = 8'hA5;
        vals[1] = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tx_exp[i]     = line_bit(vals[0], i);
            tx_exp[8 + i] = line_bit(vals[1], i);
        end
        do_reset();
        for (int k = 0; k < 24; k++) begin
            send_bit(k < 8 ? line_bit(vals[0], k) : k < 16 ? line_bit(vals[1], k - 8) : 1'b0);
            if (k >= 7 && k <= 22) tx_obs[k-7] = uio_out[0];
            total++;
            if (uio_out[1] !== (k >= 7)) begin bad++; $display("FAIL b2b_tx_active[%0d]: got %b want %b", k, uio_out[1], (k >= 7)); end
            if (k == 7) begin
                total++;
                if (uo_out !== 8'hA5) begin bad++; $display("FAIL b2b_uo_a5: got %h want a5", uo_out); end
            end
            if (k == 15) begin
                total++;
                if (uo_out !== 8'h3C) begin bad++; $display("FAIL b2b_uo_3c: got %h want 3c", uo_out); end
            end
        end
        total++;
        if (tx_obs !== tx_exp) begin bad++; $display("FAIL b2b_tx_stream: got %b want %b (bit0 first)", tx_obs, tx_exp); end
    endtask

    task automatic test_ena_pause;
        do_reset();
        for (int i = 0; i < 4; i++) send_bit(line_bit(8'h0F, i));
        ena = 1'b0;
        for (int p = 0; p < 5; p++) begin
            send_bit(p[0]);
            total++;
            if (uio_out[2] !== 1'b0) begin bad++; $display("FAIL pause_strobe[%0d]: got %b want 0", p, uio_out[2]); end
            total++;
            if (uio_out[7:3] !== 5'd0) begin bad++; $display("FAIL pause_count[%0d]: got %0d want 0", p, uio_out[7:3]); end
        end
        ena = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(line_bit(8'h0F, i));
        total++;
        if (uo_out !== 8'h0F) begin bad++; $display("FAIL pause_uo_out: got %h want 0f", uo_out); end
        total++;
        if (uio_out[2] !== 1'b1) begin bad++; $display("FAIL pause_done_strobe: got %b want 1", uio_out[2]); end
        total++;
        if (uio_out[7:3] !== 5'd1) begin bad++; $display("FAIL pause_done_count: got %0d want 1", uio_out[7:3]); end
        ena = 1'b0;
        send_bit(1'b1);
        total++;
        if (uio_out[2] !== 1'b0) begin bad++; $display("FAIL ena_low_strobe_clear: got %b want 0", uio_out[2]); end
        total++;
        if (uo_out !== 8'h0F) begin bad++; $display("FAIL ena_low_uo_hold: got %h want 0f", uo_out); end
        total++;
        if (uio_out[1:0] !== {1'b1, line_bit(8'h0F, 0)}) begin bad++; $display("FAIL ena_low_tx_hold: got %b want %b", uio_out[1:0], {1'b1, line_bit(8'h0F, 0)}); end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        send_byte(8'h5A);
        total++;
        if (uo_out !== 8'h5A) begin bad++; $display("FAIL mid_pre_uo: got %h want 5a", uo_out); end
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h00) begin bad++; $display("FAIL mid_async_uo: got %h want 00", uo_out); end
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL mid_async_uio: got %h want 00", uio_out); end
        do_reset();
        send_byte(8'h81);
        total++;
        if (uo_out !== 8'h81) begin bad++; $display("FAIL mid_uo_81: got %h want 81", uo_out); end
        total++;
        if (uio_out[7:3] !== 5'd1) begin bad++; $display("FAIL mid_count: got %0d want 1", uio_out[7:3]); end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        do_reset();
        for (int n = 0; n < 33; n++) begin
            v = 8'(n * 7 + 3);
            send_byte(v);
            total++;
            if (uo_out !== v) begin bad++; $display("FAIL wrap_uo[%0d]: got %h want %h", n, uo_out, v); end
            if (n == 30) begin
                total++;
                if (uio_out[7:3] !== 5'd31) begin bad++; $display("FAIL wrap_count31: got %0d want 31", uio_out[7:3]); end
            end
            if (n == 31) begin
                total++;
                if (uio_out[7:3] !== 5'd0) begin bad++; $display("FAIL wrap_count0: got %0d want 0", uio_out[7:3]); end
            end
        end
        total++;
        if (uio_out[7:3] !== 5'd1) begin bad++; $display("FAIL wrap_count1: got %0d want 1", uio_out[7:3]); end
    endtask

    // Raw line sequence 1,0,1,0,0,1,0,1 decodes to 0xA5 in either bit order and must echo unchanged.
    task automatic test_line_order;
        logic [7:0] seq;
        logic [7:0] echo;
        seq = 8'b1010_0101;
        do_reset();
        for (int i = 0; i < 8; i++) send_bit(seq[7-i]);
        echo[7] = uio_out[0];
        total++;
        if (uo_out !== 8'hA5) begin bad++; $display("FAIL order_uo: got %h want a5", uo_out); end
        for (int i = 1; i < 8; i++) begin
            send_bit(1'b0);
            echo[7-i] = uio_out[0];
        end
        total++;
        if (echo !== seq) begin bad++; $display("FAIL order_echo: got %b want %b", echo, seq); end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_ones();
        test_back_to_back();
        test_ena_pause();
        test_reset_mid();
        test_wrap();
        test_line_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
